// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-owner memory bus arbiter for icache, dcache and PTW
// PTW has fixed priority; icache/dcache alternate round-robin. Bursts wrap inside a 16-byte block.
module mem_arbiter (
  input  logic        clk_core,
  input  logic        reset,
  input  logic        ic_req,
  input  logic [29:0] ic_addr,
  input  logic [1:0]  ic_len,
  output logic        ic_gnt,
  output logic        ic_ack,
  output logic        ic_done,
  input  logic        dc_req,
  input  logic        dc_write,
  input  logic [29:0] dc_addr,
  input  logic [1:0]  dc_len,
  input  logic [31:0] dc_wdata,
  output logic        dc_gnt,
  output logic        dc_ack,
  output logic        dc_done,
  input  logic        pw_req,
  input  logic [29:0] pw_addr,
  output logic        pw_gnt,
  output logic        pw_ack,
  output logic [1:0]  arb_beat,
  output logic        mem_req,
  output logic        mem_write,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  typedef enum logic [1:0] {OWN_IC, OWN_DC, OWN_PW} owner_t;

  state_t      state;
  owner_t      owner;
  logic        last;
  logic        wr;
  logic [29:0] addr;
  logic [1:0]  remaining;

  logic busy;
  logic held;
  logic beat_ack;
  logic last_beat;

  // Read data goes straight from the bus to the caches; the arbiter never looks at it.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;

  always_ff @(posedge clk_core) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_IC;
      last      <= 1'b1;
      wr        <= 1'b0;
      addr      <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pw_req) begin
            owner     <= OWN_PW;
            wr        <= 1'b0;
            addr      <= pw_addr;
            remaining <= 2'd0;
            state     <= BUSY;
          end else if (ic_req && (!dc_req || last)) begin
            owner     <= OWN_IC;
            wr        <= 1'b0;
            addr      <= ic_addr;
            remaining <= ic_len;
            last      <= 1'b0;
            state     <= BUSY;
          end else if (dc_req) begin
            owner     <= OWN_DC;
            wr        <= dc_write;
            addr      <= dc_addr;
            remaining <= dc_len;
            last      <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            // Only the word offset advances, so the burst wraps within its aligned block.
            addr[1:0] <= addr[1:0] + 2'd1;
            remaining <= remaining - 2'd1;
            if (remaining == 2'd0) begin
              state <= GAP;
            end
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == BUSY);
  assign held      = (state != IDLE);
  assign beat_ack  = busy && mem_ack;
  assign last_beat = beat_ack && (remaining == 2'd0);

  assign ic_gnt  = held && (owner == OWN_IC);
  assign dc_gnt  = held && (owner == OWN_DC);
  assign pw_gnt  = held && (owner == OWN_PW);

  assign ic_ack  = beat_ack && (owner == OWN_IC);
  assign dc_ack  = beat_ack && (owner == OWN_DC);
  assign pw_ack  = beat_ack && (owner == OWN_PW);

  assign ic_done = last_beat && (owner == OWN_IC);
  assign dc_done = last_beat && (owner == OWN_DC);

  assign mem_req   = busy;
  assign mem_write = busy && wr;
  assign mem_addr  = busy ? addr : 30'd0;
  assign arb_beat  = busy ? addr[1:0] : 2'd0;
  assign mem_wdata = (busy && wr && (owner == OWN_DC)) ? dc_wdata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - table-driven and directed-sequence bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk_core = 1'b0;
  logic        reset = 1'b1;
  logic        ic_req = 1'b0;
  logic [29:0] ic_addr = '0;
  logic [1:0]  ic_len = '0;
  logic        ic_gnt, ic_ack, ic_done;
  logic        dc_req = 1'b0;
  logic        dc_write = 1'b0;
  logic [29:0] dc_addr = '0;
  logic [1:0]  dc_len = '0;
  logic [31:0] dc_wdata = '0;
  logic        dc_gnt, dc_ack, dc_done;
  logic        pw_req = 1'b0;
  logic [29:0] pw_addr = '0;
  logic        pw_gnt, pw_ack;
  logic [1:0]  arb_beat;
  logic        mem_req, mem_write;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'hA5A5_0000;

  always #5 clk_core = ~clk_core;

  mem_arbiter dut (
    .clk_core(clk_core), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_len(ic_len),
    .ic_gnt(ic_gnt), .ic_ack(ic_ack), .ic_done(ic_done),
    .dc_req(dc_req), .dc_write(dc_write), .dc_addr(dc_addr), .dc_len(dc_len),
    .dc_wdata(dc_wdata), .dc_gnt(dc_gnt), .dc_ack(dc_ack), .dc_done(dc_done),
    .pw_req(pw_req), .pw_addr(pw_addr), .pw_gnt(pw_gnt), .pw_ack(pw_ack),
    .arb_beat(arb_beat), .mem_req(mem_req), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        rst;
    logic        icr;
    logic [29:0] ica;
    logic [1:0]  icl;
    logic        dcr;
    logic        dcw;
    logic [29:0] dca;
    logic [1:0]  dcl;
    logic [31:0] wd;
    logic        ack;
    logic [2:0]  e_gnt;
    logic [2:0]  e_ack;
    logic [1:0]  e_done;
    logic        e_req;
    logic        e_wr;
    logic [29:0] e_addr;
    logic [1:0]  e_beat;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  // {pw,dc,ic} ordering for gnt/ack, {dc,ic} for done
  logic [73:0] outs;
  assign outs = {pw_gnt, dc_gnt, ic_gnt, pw_ack, dc_ack, ic_ack, dc_done, ic_done,
                 mem_req, mem_write, mem_addr, arb_beat, mem_wdata};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rst, input logic icr, input logic [29:0] ica, input logic [1:0] icl,
    input logic dcr, input logic dcw, input logic [29:0] dca, input logic [1:0] dcl,
    input logic [31:0] wd, input logic ack,
    input logic [2:0] g, input logic [2:0] a, input logic [1:0] d,
    input logic rq, input logic w, input logic [29:0] ad, input logic [1:0] b,
    input logic [31:0] wdo);
    vec_t v;
    v.rst = rst; v.icr = icr; v.ica = ica; v.icl = icl;
    v.dcr = dcr; v.dcw = dcw; v.dca = dca; v.dcl = dcl; v.wd = wd; v.ack = ack;
    v.e_gnt = g; v.e_ack = a; v.e_done = d; v.e_req = rq; v.e_wr = w;
    v.e_addr = ad; v.e_beat = b; v.e_wdata = wdo;
    return v;
  endfunction

  initial begin
    repeat (2) @(posedge clk_core);

    // icache 4-beat read from 0x1000, ack every cycle
    vecs.push_back(mk(1,0,0,0,     0,0,0,0,0,0,         0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,30'h400,3, 0,0,0,0,0,1,       0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,30'h400,3, 0,0,0,0,0,1,       3'b001,3'b001,2'b00,1,0,30'h400,0,0));
    vecs.push_back(mk(0,1,30'h400,3, 0,0,0,0,0,1,       3'b001,3'b001,2'b00,1,0,30'h401,1,0));
    vecs.push_back(mk(0,1,30'h400,3, 0,0,0,0,0,1,       3'b001,3'b001,2'b00,1,0,30'h402,2,0));
    vecs.push_back(mk(0,1,30'h400,3, 0,0,0,0,0,1,       3'b001,3'b001,2'b01,1,0,30'h403,3,0));
    vecs.push_back(mk(0,0,0,0,     0,0,0,0,0,1,         3'b001,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,     0,0,0,0,0,0,         0,0,0,0,0,0,0,0));
    // dcache 4-beat writeback from 0x2008, ack every other cycle, wraps 2,3,0,1
    vecs.push_back(mk(0,0,0,0, 1,1,30'h802,3,32'h0,0,          0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,1,30'h802,3,32'hD000_0002,0,  3'b010,0,0,1,1,30'h802,2,32'hD000_0002));
    vecs.push_back(mk(0,0,0,0, 1,1,30'h802,3,32'hD000_0002,1,  3'b010,3'b010,0,1,1,30'h802,2,32'hD000_0002));
    vecs.push_back(mk(0,0,0,0, 1,1,30'h802,3,32'hD000_0003,0,  3'b010,0,0,1,1,30'h803,3,32'hD000_0003));
    vecs.push_back(mk(0,0,0,0, 1,1,30'h802,3,32'hD000_0003,1,  3'b010,3'b010,0,1,1,30'h803,3,32'hD000_0003));
    vecs.push_back(mk(0,0,0,0, 1,1,30'h802,3,32'hD000_0000,0,  3'b010,0,0,1,1,30'h800,0,32'hD000_0000));
    vecs.push_back(mk(0,0,0,0, 1,1,30'h802,3,32'hD000_0000,1,  3'b010,3'b010,0,1,1,30'h800,0,32'hD000_0000));
    vecs.push_back(mk(0,0,0,0, 1,1,30'h802,3,32'hD000_0001,0,  3'b010,0,0,1,1,30'h801,1,32'hD000_0001));
    vecs.push_back(mk(0,0,0,0, 1,1,30'h802,3,32'hD000_0001,1,  3'b010,3'b010,2'b10,1,1,30'h801,1,32'hD000_0001));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,0,0,                    3'b010,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,0,0,                    0,0,0,0,0,0,0,0));
    // simultaneous ic/dc from reset: ic, dc, ic, dc; read data must not leak onto mem_wdata
    vecs.push_back(mk(1,1,30'h010,0, 1,0,30'h020,0,32'hFFFF_FFFF,0, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,30'h010,0, 1,0,30'h020,0,32'hFFFF_FFFF,0, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,30'h010,0, 1,0,30'h020,0,32'hFFFF_FFFF,1, 3'b001,3'b001,2'b01,1,0,30'h010,0,0));
    vecs.push_back(mk(0,1,30'h010,0, 1,0,30'h020,0,32'hFFFF_FFFF,0, 3'b001,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,30'h010,0, 1,0,30'h020,0,32'hFFFF_FFFF,0, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,30'h010,0, 1,0,30'h020,0,32'hFFFF_FFFF,1, 3'b010,3'b010,2'b10,1,0,30'h020,0,0));
    vecs.push_back(mk(0,1,30'h010,0, 1,0,30'h020,0,32'hFFFF_FFFF,0, 3'b010,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,30'h010,0, 1,0,30'h020,0,32'hFFFF_FFFF,0, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,30'h010,0, 1,0,30'h020,0,32'hFFFF_FFFF,1, 3'b001,3'b001,2'b01,1,0,30'h010,0,0));
    vecs.push_back(mk(0,1,30'h010,0, 1,0,30'h020,0,32'hFFFF_FFFF,0, 3'b001,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,30'h010,0, 1,0,30'h020,0,32'hFFFF_FFFF,0, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,30'h010,0, 1,0,30'h020,0,32'hFFFF_FFFF,1, 3'b010,3'b010,2'b10,1,0,30'h020,0,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,0,0,0,                   3'b010,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,0,0,0,                   0,0,0,0,0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_core);
      reset = vecs[i].rst; ic_req = vecs[i].icr; ic_addr = vecs[i].ica; ic_len = vecs[i].icl;
      dc_req = vecs[i].dcr; dc_write = vecs[i].dcw; dc_addr = vecs[i].dca; dc_len = vecs[i].dcl;
      dc_wdata = vecs[i].wd; mem_ack = vecs[i].ack; pw_req = 1'b0;
      mem_rdata = 32'hA5A5_0000 + i;
      #4;
      chk($sformatf("vec%0d", i), outs,
          {vecs[i].e_gnt, vecs[i].e_ack, vecs[i].e_done, vecs[i].e_req, vecs[i].e_wr,
           vecs[i].e_addr, vecs[i].e_beat, vecs[i].e_wdata});
    end

    // PTW raised mid icache burst with dcache pending: ic finishes, then PTW, then dc
    @(negedge clk_core); ic_req = 1'b1; ic_addr = 30'h100; ic_len = 2'd1; mem_ack = 1'b0;
    #4 chk("ptw_pre_idle", {pw_gnt, dc_gnt, ic_gnt}, 3'b000);
    @(negedge clk_core); pw_req = 1'b1; pw_addr = 30'h3FF;
    dc_req = 1'b1; dc_write = 1'b0; dc_addr = 30'h200; dc_len = 2'd0; mem_ack = 1'b1;
    #4 chk("ptw_ic_beat0", {pw_gnt, dc_gnt, ic_gnt, ic_ack, mem_addr}, {3'b001, 1'b1, 30'h100});
    @(negedge clk_core);
    #4 chk("ptw_ic_done", {pw_gnt, ic_done, mem_addr}, {1'b0, 1'b1, 30'h101});
    @(negedge clk_core); ic_req = 1'b0; mem_ack = 1'b0;
    #4 chk("ptw_ic_gap", {pw_gnt, dc_gnt, ic_gnt, mem_req}, 4'b0010);
    @(negedge clk_core);
    #4 chk("ptw_idle", {pw_gnt, dc_gnt, ic_gnt, mem_req}, 4'b0000);
    @(negedge clk_core); mem_ack = 1'b1;
    #4 chk("ptw_beat", {pw_gnt, dc_gnt, ic_gnt, pw_ack, mem_req, mem_write, mem_addr, arb_beat},
           {3'b100, 1'b1, 1'b1, 1'b0, 30'h3FF, 2'd3});
    @(negedge clk_core); pw_req = 1'b0;
    #4 chk("ptw_gap_ack_ignored", {pw_gnt, pw_ack, mem_req}, 3'b100);
    @(negedge clk_core); mem_ack = 1'b0;
    #4 chk("ptw_idle2", {pw_gnt, dc_gnt, ic_gnt}, 3'b000);
    @(negedge clk_core); mem_ack = 1'b1;
    #4 chk("dc_after_ptw", {pw_gnt, dc_gnt, ic_gnt, dc_ack, dc_done, mem_addr},
           {3'b010, 2'b11, 30'h200});
    @(negedge clk_core); dc_req = 1'b0; mem_ack = 1'b0;
    #4 chk("dc_after_ptw_gap", {dc_gnt, mem_req}, 2'b10);
    @(negedge clk_core);
    #4 chk("seq_idle", {pw_gnt, dc_gnt, ic_gnt}, 3'b000);

    // Reset after two of four beats; the icache then wins the first tie again
    @(negedge clk_core); ic_req = 1'b1; ic_addr = 30'h400; ic_len = 2'd3; mem_ack = 1'b0;
    #4 chk("rst_pre_idle", {ic_gnt, mem_req}, 2'b00);
    @(negedge clk_core); mem_ack = 1'b1;
    #4 chk("rst_beat0", {ic_gnt, ic_ack, mem_addr}, {2'b11, 30'h400});
    @(negedge clk_core);
    #4 chk("rst_beat1", {ic_gnt, ic_ack, mem_addr}, {2'b11, 30'h401});
    @(negedge clk_core); mem_ack = 1'b0; reset = 1'b1;
    #4 chk("rst_busy", {mem_req, mem_addr, arb_beat}, {1'b1, 30'h402, 2'd2});
    @(negedge clk_core); reset = 1'b0;
    dc_req = 1'b1; dc_write = 1'b0; dc_addr = 30'h200; dc_len = 2'd0;
    #4 chk("rst_after", {pw_gnt, dc_gnt, ic_gnt, mem_req, mem_write, mem_addr, arb_beat}, 37'd0);
    @(negedge clk_core);
    #4 chk("rst_tie_ic", {dc_gnt, ic_gnt, mem_req, mem_addr}, {3'b011, 30'h400});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-owner arbiter sharing the core's one memory bus between instruction-cache refills, data-cache refills/writebacks and the page-table walker. It sits below the icache, dcache and PTW and above the memory interface. It grants one requester at a time and sequences a 1–4 beat burst on the bus. It routes per-beat acknowledges and data back to the owner.

## Interface
- No parameters.
- clk_core  in  1  core clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- ic_req  in  1  icache refill request (read only); held until ic_done
- ic_addr  in  30  [31:2] start word address
- ic_len  in  2  beats minus one
- ic_gnt  out  1  icache owns bus
- ic_ack  out  1  icache beat complete; mem_rdata valid
- ic_done  out  1  last icache beat complete
- dc_req  in  1  dcache request; held until dc_done
- dc_write  in  1  1 = writeback, 0 = refill
- dc_addr  in  30  [31:2] start word address
- dc_len  in  2  beats minus one
- dc_wdata  in  32  write data for beat arb_beat
- dc_gnt / dc_ack / dc_done  out  1 each  as for icache
- pw_req  in  1  PTW single-word read; held until pw_ack
- pw_addr  in  30  [31:2] PTE word address
- pw_gnt / pw_ack  out  1 each  PTW owns bus / read complete (also its done)
- arb_beat  out  2  word offset (addr[3:2]) of the current beat
- mem_req  out  1  bus beat request
- mem_write  out  1  beat is a write
- mem_addr  out  30  [31:2] beat word address
- mem_wdata  out  32  = dc_wdata when the dcache owns a write, else 0
- mem_ack  in  1  current beat accepted/completed
- mem_rdata  in  32  read data, valid with mem_ack; passed to requesters unregistered

## Operation
- FSM states: IDLE, BUSY, GAP.
- IDLE: evaluate requests.
  - If pw_req is set, PTW wins (fixed highest priority).
  - Otherwise arbitrate ic/dc round-robin. Pointer `last` is 0 = ic, 1 = dc. If both request, grant the one not equal to `last`. A single requester always wins.
  - Registers loaded on a grant: owner, write, addr[31:2], remaining = len (PTW: 0).
  - Next state is BUSY. `last` updates only on ic/dc grants.
- BUSY:
  - mem_req = 1, mem_addr = latched addr, mem_write = latched write.
  - On mem_ack, the owner's *_ack pulses for that cycle. addr[3:2] increments modulo 4 (wrap within the 16-byte aligned block; addr[31:4] never changes). remaining decrements.
  - On mem_ack with remaining == 0: owner *_done pulses (pw_ack serves as PTW done), next state is GAP.
- GAP: one idle cycle, mem_req = 0. Requesters drop req here. Next state is IDLE.
- *_gnt is high for the owner throughout BUSY and GAP, and low in IDLE.
- arb_beat = latched addr[3:2] in BUSY. The dcache presents dc_wdata for that word combinationally.
- Requests are sampled only in IDLE. Requests raised during BUSY wait, and req changes by the owner during BUSY are ignored.

## Timing
- Reset values: state IDLE, `last` = 1 (icache wins the first tie), all *_gnt/*_ack/*_done = 0, mem_req = 0, mem_write = 0, mem_addr = 0, arb_beat = 0.
- Request latency: req high in IDLE at cycle N gives gnt and mem_req at N+1.
- Beats: one beat completes per cycle with mem_ack. Minimum n-beat transaction is 1 + n + 1 cycles (IDLE, n beats, GAP).
- mem_req stays asserted until the final mem_ack. mem_addr is stable while mem_ack is low.
- mem_ack while not in BUSY is ignored.
- Reset during BUSY: next cycle the state is IDLE with mem_req = 0. The burst is abandoned; bus and requesters are reset by the same signal.
- len = 3 starting at addr[3:2] = 2 issues words 2, 3, 0, 1.

## Test plan
- ic_req, addr 0x1000>>2, len 3, mem_ack every cycle → mem_addr words 0x400, 0x401, 0x402, 0x403 on cycles 1–4. ic_ack on each. ic_done on cycle 4. Idle on cycle 5.
- dc_req write, addr 0x2008>>2, len 3, mem_ack every other cycle → offsets 2, 3, 0, 1. mem_write = 1. mem_wdata tracks dc_wdata per arb_beat. dc_done on the 4th ack.
- ic_req and dc_req asserted together from reset and held → order is ic, dc, ic, dc. Each grant is separated by one GAP cycle.
- pw_req raised during an icache burst, with dc_req also pending → the icache burst completes. PTW is granted next, then dcache. pw_ack gives a single beat.
- Reset asserted mid-burst after 2 of 4 beats → the next cycle has mem_req = 0, all gnt = 0, and state IDLE. The first request afterwards is granted to the icache on a tie.
